// File: rtl/neuron_layer_ctrl_pkg.sv
// Shared types for the neuron layer sequencer: Q8.7 data word, FSM states, watchdog limit.
package neuron_pkg;

  typedef logic signed [15:0] data_t;

  localparam int unsigned FRAC_BITS   = 7;
  localparam int unsigned TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    FINISH,
    WAIT_RES,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/neuron_layer_ctrl_if.sv
// Layer-control / BRAM / neuron-result bundle. po_error exists only with NEURON_CTRL_TIMEOUT_EN.
interface neuron_layer_ctrl_if #(
  parameter int unsigned IN_AW = 10,
  parameter int unsigned W_AW  = 13,
  parameter int unsigned N_AW  = 4
);
  import neuron_pkg::*;

  logic              pi_start;
  logic              po_busy;
  logic              po_done;
  logic [IN_AW-1:0]  po_input_addr;
  logic [W_AW-1:0]   po_weight_addr;
  logic [N_AW-1:0]   po_bias_addr;
  logic              po_BRAM_en;
  logic              po_valid;
  logic              po_clc_accumulator;
  logic              po_accumulation_done;
  logic              pi_result_valid;
  data_t             pi_result;
  logic              po_out_we;
  logic [N_AW-1:0]   po_out_addr;
  data_t             po_out_data;
`ifdef NEURON_CTRL_TIMEOUT_EN
  logic              po_error;
`endif

  modport master (
    input  pi_start, pi_result_valid, pi_result,
    output po_busy, po_done, po_input_addr, po_weight_addr, po_bias_addr, po_BRAM_en,
           po_valid, po_clc_accumulator, po_accumulation_done, po_out_we, po_out_addr,
           po_out_data
`ifdef NEURON_CTRL_TIMEOUT_EN
    , output po_error
`endif
  );

  modport slave (
    output pi_start, pi_result_valid, pi_result,
    input  po_busy, po_done, po_input_addr, po_weight_addr, po_bias_addr, po_BRAM_en,
           po_valid, po_clc_accumulator, po_accumulation_done, po_out_we, po_out_addr,
           po_out_data
`ifdef NEURON_CTRL_TIMEOUT_EN
    , input po_error
`endif
  );

endinterface

// File: rtl/neuron_layer_ctrl_valid_delay_line.sv
// Fixed-depth shift register that aligns the operand-valid strobe to BRAM read latency.
module valid_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic pi_clk,
  input  logic pi_rst,
  input  logic pi_in,
  output logic po_out
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) sr_q <= '0;
        else         sr_q <= pi_in;
      end
    end else begin : g_multi
      always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) sr_q <= '0;
        else         sr_q <= {sr_q[DEPTH-2:0], pi_in};
      end
    end
  endgenerate

  assign po_out = sr_q[DEPTH-1];

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for a time-multiplexed MAC neuron: walks neurons x inputs and collects results.
// Optional WAIT_RES watchdog and po_error port enabled by NEURON_CTRL_TIMEOUT_EN.
module neuron_layer_ctrl
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned BRAM_LAT    = 1,
  parameter int unsigned IN_AW       = 10,
  parameter int unsigned W_AW        = 13,
  parameter int unsigned N_AW        = 4
) (
  input  logic                pi_clk,
  input  logic                pi_rst,
  neuron_layer_ctrl_if.master bus
);

  localparam logic [IN_AW-1:0] LAST_IN    = IN_AW'(NUM_INPUTS - 1);
  localparam logic [N_AW-1:0]  LAST_N     = N_AW'(NUM_NEURONS - 1);
  localparam logic [2:0]       LAST_DRAIN = 3'(BRAM_LAT - 1);
  localparam logic [W_AW-1:0]  W_STEP     = W_AW'(NUM_INPUTS);

  ctrl_state_e      state_q;
  logic [IN_AW-1:0] i_q;
  logic [N_AW-1:0]  n_q;
  logic [W_AW-1:0]  base_q;
  logic [W_AW-1:0]  w_q;
  logic [2:0]       d_q;
  logic             busy_q, done_q, en_q, clc_q, acc_q, we_q;
  logic [N_AW-1:0]  oaddr_q;
  data_t            odata_q;
  logic             valid;
`ifdef NEURON_CTRL_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0]      wd_q;
  logic             error_q;
`endif

  always_ff @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      w_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      clc_q   <= 1'b0;
      acc_q   <= 1'b0;
      we_q    <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
`ifdef NEURON_CTRL_TIMEOUT_EN
      wd_q    <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      clc_q  <= 1'b0;
      acc_q  <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.pi_start) begin
            n_q     <= '0;
            base_q  <= '0;
            clc_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          i_q     <= '0;
          w_q     <= base_q;
          en_q    <= 1'b1;
          state_q <= STREAM;
        end
        STREAM: begin
          // Counters hold at the last input so no out-of-range address is ever presented.
          if (i_q == LAST_IN) begin
            en_q    <= 1'b0;
            d_q     <= '0;
            state_q <= DRAIN;
          end else begin
            i_q <= i_q + IN_AW'(1);
            w_q <= w_q + W_AW'(1);
          end
        end
        DRAIN: begin
          if (d_q == LAST_DRAIN) begin
            acc_q   <= 1'b1;
            state_q <= FINISH;
          end else begin
            d_q <= d_q + 3'd1;
          end
        end
        FINISH: begin
`ifdef NEURON_CTRL_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= WAIT_RES;
        end
        WAIT_RES: begin
          if (bus.pi_result_valid) begin
            odata_q <= bus.pi_result;
            oaddr_q <= n_q;
            we_q    <= 1'b1;
            if (n_q == LAST_N) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              n_q     <= n_q + N_AW'(1);
              base_q  <= base_q + W_STEP;
              clc_q   <= 1'b1;
              state_q <= CLEAR;
            end
          end
`ifdef NEURON_CTRL_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH (BRAM_LAT)
  ) u_valid_dly (
    .pi_clk (pi_clk),
    .pi_rst (pi_rst),
    .pi_in  (en_q),
    .po_out (valid)
  );

  assign bus.po_busy              = busy_q;
  assign bus.po_done              = done_q;
  assign bus.po_input_addr        = i_q;
  assign bus.po_weight_addr       = w_q;
  assign bus.po_bias_addr         = n_q;
  assign bus.po_BRAM_en           = en_q;
  assign bus.po_valid             = valid;
  assign bus.po_clc_accumulator   = clc_q;
  assign bus.po_accumulation_done = acc_q;
  assign bus.po_out_we            = we_q;
  assign bus.po_out_addr          = oaddr_q;
  assign bus.po_out_data          = odata_q;
`ifdef NEURON_CTRL_TIMEOUT_EN
  assign bus.po_error             = error_q;
`endif

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench: two DUTs (BRAM_LAT 1 and 3), 4 inputs x 2 neurons, result path, restart, abort.
module tb_neuron_layer_ctrl;
  import neuron_pkg::*;

  logic  pi_clk = 1'b0;
  logic  pi_rst = 1'b0;
  logic  sel    = 1'b0;
  logic  start  = 1'b0;
  logic  rv     = 1'b0;
  data_t result = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pi_clk = ~pi_clk;

  neuron_layer_ctrl_if #(.IN_AW(3), .W_AW(4), .N_AW(2)) ifa ();
  neuron_layer_ctrl_if #(.IN_AW(3), .W_AW(4), .N_AW(2)) ifb ();

  assign ifa.pi_start        = start & ~sel;
  assign ifb.pi_start        = start & sel;
  assign ifa.pi_result_valid = rv & ~sel;
  assign ifb.pi_result_valid = rv & sel;
  assign ifa.pi_result       = result;
  assign ifb.pi_result       = result;

  neuron_layer_ctrl #(
    .NUM_INPUTS(4), .NUM_NEURONS(2), .BRAM_LAT(1), .IN_AW(3), .W_AW(4), .N_AW(2)
  ) u_dut_a (
    .pi_clk (pi_clk),
    .pi_rst (pi_rst),
    .bus    (ifa)
  );

  neuron_layer_ctrl #(
    .NUM_INPUTS(4), .NUM_NEURONS(2), .BRAM_LAT(3), .IN_AW(3), .W_AW(4), .N_AW(2)
  ) u_dut_b (
    .pi_clk (pi_clk),
    .pi_rst (pi_rst),
    .bus    (ifb)
  );

  // Observe whichever DUT is selected.
  logic m_busy, m_done, m_en, m_valid, m_clc, m_acc, m_we;
  logic [2:0] m_in;
  logic [3:0] m_w;
  logic [1:0] m_b, m_oaddr;
  data_t      m_odata;
  assign m_busy  = sel ? ifb.po_busy : ifa.po_busy;
  assign m_done  = sel ? ifb.po_done : ifa.po_done;
  assign m_en    = sel ? ifb.po_BRAM_en : ifa.po_BRAM_en;
  assign m_valid = sel ? ifb.po_valid : ifa.po_valid;
  assign m_clc   = sel ? ifb.po_clc_accumulator : ifa.po_clc_accumulator;
  assign m_acc   = sel ? ifb.po_accumulation_done : ifa.po_accumulation_done;
  assign m_we    = sel ? ifb.po_out_we : ifa.po_out_we;
  assign m_in    = sel ? ifb.po_input_addr : ifa.po_input_addr;
  assign m_w     = sel ? ifb.po_weight_addr : ifa.po_weight_addr;
  assign m_b     = sel ? ifb.po_bias_addr : ifa.po_bias_addr;
  assign m_oaddr = sel ? ifb.po_out_addr : ifa.po_out_addr;
  assign m_odata = sel ? ifb.po_out_data : ifa.po_out_data;
`ifdef NEURON_CTRL_TIMEOUT_EN
  logic m_err;
  assign m_err = sel ? ifb.po_error : ifa.po_error;
`endif

  // Per-run observations.
  logic [31:0] in_seq, w_seq, b_seq;
  int          en_cnt, vcnt0, vcnt1, acc_cnt, acc_bad, lag_bad, done_cnt, busy_bad;
  int          tmo_cyc;
  logic        busy_at_err, all_zero;
  logic [17:0] wr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic outs_zero();
    return ({m_busy, m_done, m_en, m_valid, m_clc, m_acc, m_we, m_in, m_w, m_b, m_oaddr,
             m_odata} == '0);
  endfunction

  // mode 0: normal, 1: start+junk result during STREAM, 2: async reset in neuron 1, 3: no result
  task automatic run_layer(input int lat, input int mode);
    int         rsp_cnt = 0;
    int         post = 0;
    int         nres = 0;
    int         tmo_k = -1;
    bit         mid_done = 0;
    bit         aborted = 0;
    bit         prev_valid = 0;
    logic [7:0] en_hist = '0;
    in_seq = '0; w_seq = '0; b_seq = '0;
    en_cnt = 0; vcnt0 = 0; vcnt1 = 0; acc_cnt = 0; acc_bad = 0; lag_bad = 0;
    done_cnt = 0; busy_bad = 0; tmo_cyc = -1; busy_at_err = 1'b1; all_zero = 1'b0;
    wr_q.delete();
    @(posedge pi_clk); #1;
    start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge pi_clk); #1;
      start = 1'b0;
      rv    = 1'b0;
      if (aborted) begin
        post++;
        if (m_done) done_cnt++;
        if (post == 4) begin
          pi_rst = 1'b1;
          break;
        end
        continue;
      end
      en_hist = {en_hist[6:0], m_en};
      if (m_valid != en_hist[lat]) lag_bad++;
      if (m_en) begin
        in_seq = {in_seq[27:0], 1'b0, m_in};
        w_seq  = {w_seq[27:0], m_w};
        b_seq  = {b_seq[27:0], 2'b00, m_b};
        en_cnt++;
        if (!m_busy) busy_bad++;
      end
      if (m_valid) begin
        if (m_b == 2'd0) vcnt0++;
        else             vcnt1++;
      end
      if (tmo_k >= 0) tmo_k++;
      if (m_acc) begin
        acc_cnt++;
        if (!(prev_valid && !m_valid)) acc_bad++;
        if (mode == 3) tmo_k = 0;
        else           rsp_cnt = 2;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rv     = 1'b1;
          result = (nres == 0) ? 16'h0340 : 16'hFF80;
          nres++;
        end
      end
      prev_valid = m_valid;
      if (m_we) wr_q.push_back({m_oaddr, m_odata});
      if (m_done) begin
        done_cnt++;
        if (m_busy) busy_bad++;
      end
      if (mode == 1 && m_en && m_in == 3'd1 && !mid_done) begin
        start    = 1'b1;
        rv       = 1'b1;
        result   = 16'h7777;
        mid_done = 1'b1;
      end
      if (mode == 2 && m_en && m_b == 2'd1) begin
        #2 pi_rst = 1'b0;
        #1 all_zero = outs_zero();
        aborted = 1'b1;
      end
`ifdef NEURON_CTRL_TIMEOUT_EN
      if (mode == 3 && m_err && tmo_cyc < 0) begin
        tmo_cyc     = tmo_k;
        busy_at_err = m_busy;
      end
      if (tmo_cyc >= 0) post++;
`endif
      if (done_cnt > 0) post++;
      if (post >= 3) break;
    end
    start = 1'b0;
    rv    = 1'b0;
  endtask

  task automatic check_layer(input string pfx);
    check_eq({pfx, "_done_cnt"}, done_cnt, 1);
    check_eq({pfx, "_in_addr_seq"}, in_seq, 32'h0123_0123);
    check_eq({pfx, "_w_addr_seq"}, w_seq, 32'h0123_4567);
    check_eq({pfx, "_bias_seq"}, b_seq, 32'h0000_1111);
    check_eq({pfx, "_en_cnt"}, en_cnt, 8);
    check_eq({pfx, "_valid_n0"}, vcnt0, 4);
    check_eq({pfx, "_valid_n1"}, vcnt1, 4);
    check_eq({pfx, "_valid_lag"}, lag_bad, 0);
    check_eq({pfx, "_acc_cnt"}, acc_cnt, 2);
    check_eq({pfx, "_acc_after_valid"}, acc_bad, 0);
    check_eq({pfx, "_busy"}, busy_bad, 0);
    check_eq({pfx, "_wr_cnt"}, wr_q.size(), 2);
    check_eq({pfx, "_wr0"}, (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD, 32'h0_0340);
    check_eq({pfx, "_wr1"}, (wr_q.size() > 1) ? 32'(wr_q[1]) : 32'hDEAD, 32'h1_FF80);
  endtask

  initial begin
    #2;
    sel = 1'b0;
    #1 check_eq("rst_outs_a", outs_zero(), 1'b1);
    sel = 1'b1;
    #1 check_eq("rst_outs_b", outs_zero(), 1'b1);
    sel = 1'b0;
    repeat (2) @(posedge pi_clk);
    #3 pi_rst = 1'b1;

    run_layer(1, 0);
    check_layer("a_lat1");

    run_layer(1, 1);
    check_layer("a_midstart");

    run_layer(1, 2);
    check_eq("abort_outs_zero", all_zero, 1'b1);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_idle_outs", outs_zero(), 1'b1);

    run_layer(1, 0);
    check_layer("a_restart");

    sel = 1'b1;
    run_layer(3, 0);
    check_layer("b_lat3");
    sel = 1'b0;

`ifdef NEURON_CTRL_TIMEOUT_EN
    check_eq("err_clear_before", ifa.po_error, 1'b0);
    run_layer(1, 3);
    check_eq("tmo_cycles", tmo_cyc, 1025);
    check_eq("tmo_busy", busy_at_err, 1'b0);
    check_eq("tmo_no_done", done_cnt, 0);
    check_eq("tmo_sticky", m_err, 1'b1);
    check_eq("tmo_idle_en", m_en, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
